// File: rtl/serial_fifo_bridge.sv
// Byte bridge between a processor serial port and a host valid/ready link:
// one RX FIFO (host -> cpu) and one TX FIFO (cpu -> host), both first-word-fall-through.

module serial_fifo_bridge_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_valid,
    input  logic [7:0]                 push_data,
    output logic                       push_ready,
    input  logic                       pop_req,
    output logic                       pop_valid,
    output logic [7:0]                 pop_data,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Ready and valid come from the pre-edge count, so a full FIFO never
    // accepts a push and an empty FIFO never pops, even with same-edge traffic.
    assign push_ready = (count < FULL_COUNT);
    assign pop_valid  = (count != '0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_req && pop_valid;
    assign pop_data   = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is left uninitialised; a stale write on a reset edge is never observable.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

module serial_fifo_bridge #(
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [7:0]             cpu_rdata_out,
    output logic                   cpu_rvalid_out,
    input  logic                   cpu_rden_in,
    input  logic [7:0]             cpu_wdata_in,
    input  logic                   cpu_wren_in,
    output logic                   cpu_wready_out,
    input  logic [7:0]             host_rx_data_in,
    input  logic                   host_rx_valid_in,
    output logic                   host_rx_ready_out,
    output logic [7:0]             host_tx_data_out,
    output logic                   host_tx_valid_out,
    input  logic                   host_tx_ready_in,
    output logic [$clog2(DEPTH):0] rx_count_out,
    output logic [$clog2(DEPTH):0] tx_count_out,
    output logic                   rx_underflow_out,
    output logic                   tx_drop_out
);
    serial_fifo_bridge_fifo #(.DEPTH(DEPTH)) rx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (host_rx_valid_in),
        .push_data  (host_rx_data_in),
        .push_ready (host_rx_ready_out),
        .pop_req    (cpu_rden_in),
        .pop_valid  (cpu_rvalid_out),
        .pop_data   (cpu_rdata_out),
        .count      (rx_count_out)
    );

    serial_fifo_bridge_fifo #(.DEPTH(DEPTH)) tx_fifo (
        .clock      (clock),
        .reset      (reset),
        .push_valid (cpu_wren_in),
        .push_data  (cpu_wdata_in),
        .push_ready (cpu_wready_out),
        .pop_req    (host_tx_ready_in),
        .pop_valid  (host_tx_valid_out),
        .pop_data   (host_tx_data_out),
        .count      (tx_count_out)
    );

    // Sticky error flags: a read of an empty RX FIFO or a write into a full
    // TX FIFO is remembered until the next reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rx_underflow_out <= 1'b0;
            tx_drop_out      <= 1'b0;
        end else begin
            if (cpu_rden_in && !cpu_rvalid_out) rx_underflow_out <= 1'b1;
            if (cpu_wren_in && !cpu_wready_out) tx_drop_out      <= 1'b1;
        end
    end
endmodule

// File: tb/tb_serial_fifo_bridge.sv
// Self-checking bench for serial_fifo_bridge: constant vector table, directed
// corner-case sequences, and randomized traffic against a queue-based model.

module tb_serial_fifo_bridge;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    cpu_rdata_out;
    logic          cpu_rvalid_out;
    logic          cpu_rden_in;
    logic [7:0]    cpu_wdata_in;
    logic          cpu_wren_in;
    logic          cpu_wready_out;
    logic [7:0]    host_rx_data_in;
    logic          host_rx_valid_in;
    logic          host_rx_ready_out;
    logic [7:0]    host_tx_data_out;
    logic          host_tx_valid_out;
    logic          host_tx_ready_in;
    logic [CW-1:0] rx_count_out;
    logic [CW-1:0] tx_count_out;
    logic          rx_underflow_out;
    logic          tx_drop_out;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: plain queues plus two sticky bits
    byte unsigned m_rx[$];
    byte unsigned m_tx[$];
    bit           m_under;
    bit           m_drop;

    typedef struct {
        logic       rst;
        logic       rxv;
        logic [7:0] rxd;
        logic       rden;
        logic       wren;
        logic [7:0] wd;
        logic       txr;
        int         rxc;
        int         txc;
        logic [7:0] rx_head;
        logic [7:0] tx_head;
        logic       und;
        logic       drp;
    } vec_t;

    vec_t vecs[7];

    always #5 clock = ~clock;

    serial_fifo_bridge #(.DEPTH(DEPTH)) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_rdata_out     (cpu_rdata_out),
        .cpu_rvalid_out    (cpu_rvalid_out),
        .cpu_rden_in       (cpu_rden_in),
        .cpu_wdata_in      (cpu_wdata_in),
        .cpu_wren_in       (cpu_wren_in),
        .cpu_wready_out    (cpu_wready_out),
        .host_rx_data_in   (host_rx_data_in),
        .host_rx_valid_in  (host_rx_valid_in),
        .host_rx_ready_out (host_rx_ready_out),
        .host_tx_data_out  (host_tx_data_out),
        .host_tx_valid_out (host_tx_valid_out),
        .host_tx_ready_in  (host_tx_ready_in),
        .rx_count_out      (rx_count_out),
        .tx_count_out      (tx_count_out),
        .rx_underflow_out  (rx_underflow_out),
        .tx_drop_out       (tx_drop_out)
    );

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic setInputs(input logic rst, input logic rxv, input logic [7:0] rxd,
                             input logic rden, input logic wren, input logic [7:0] wd,
                             input logic txr);
        reset            = rst;
        host_rx_valid_in = rxv;
        host_rx_data_in  = rxd;
        cpu_rden_in      = rden;
        cpu_wren_in      = wren;
        cpu_wdata_in     = wd;
        host_tx_ready_in = txr;
    endtask

    // Queue-level view of one clock edge using the currently driven inputs
    task automatic modelEdge();
        bit rx_push, rx_pop, tx_push, tx_pop;
        if (!reset) begin
            m_rx.delete();
            m_tx.delete();
            m_under = 1'b0;
            m_drop  = 1'b0;
        end else begin
            rx_push = host_rx_valid_in && (m_rx.size() < DEPTH);
            rx_pop  = cpu_rden_in && (m_rx.size() > 0);
            tx_push = cpu_wren_in && (m_tx.size() < DEPTH);
            tx_pop  = host_tx_ready_in && (m_tx.size() > 0);
            if (cpu_rden_in && m_rx.size() == 0) m_under = 1'b1;
            if (cpu_wren_in && m_tx.size() == DEPTH) m_drop = 1'b1;
            if (rx_pop)  void'(m_rx.pop_front());
            if (rx_push) m_rx.push_back(host_rx_data_in);
            if (tx_pop)  void'(m_tx.pop_front());
            if (tx_push) m_tx.push_back(cpu_wdata_in);
        end
    endtask

    task automatic applyStimulus();
        modelEdge();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".rx_count"},  rx_count_out,      m_rx.size());
        checkVal({tag, ".tx_count"},  tx_count_out,      m_tx.size());
        checkVal({tag, ".rvalid"},    cpu_rvalid_out,    m_rx.size() != 0);
        checkVal({tag, ".tx_valid"},  host_tx_valid_out, m_tx.size() != 0);
        checkVal({tag, ".rx_ready"},  host_rx_ready_out, m_rx.size() < DEPTH);
        checkVal({tag, ".wready"},    cpu_wready_out,    m_tx.size() < DEPTH);
        checkVal({tag, ".underflow"}, rx_underflow_out,  m_under);
        checkVal({tag, ".drop"},      tx_drop_out,       m_drop);
        if (m_rx.size() != 0) checkVal({tag, ".rdata"},   cpu_rdata_out,    m_rx[0]);
        if (m_tx.size() != 0) checkVal({tag, ".tx_data"}, host_tx_data_out, m_tx[0]);
    endtask

    task automatic doReset();
        setInputs(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0, 8'h00, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1, 0, 8'h11, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 8'h33, 1'b0, 2, 1, 8'h11, 8'h33, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'h44, 1'b1, 1'b0, 8'h00, 1'b0, 2, 1, 8'h22, 8'h33, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 2, 1, 8'h22, 8'h55, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 8'h77, 1'b1, 0, 0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66, 1'b1, 0, 1, 8'h00, 8'h66, 1'b0, 1'b0};

        doReset();
        checkVal("reset.rx_count", rx_count_out,      0);
        checkVal("reset.tx_count", tx_count_out,      0);
        checkVal("reset.rvalid",   cpu_rvalid_out,    0);
        checkVal("reset.tx_valid", host_tx_valid_out, 0);
        checkVal("reset.wready",   cpu_wready_out,    1);
        checkVal("reset.rx_ready", host_rx_ready_out, 1);

        for (int i = 0; i < 7; i++) begin
            setInputs(vecs[i].rst, vecs[i].rxv, vecs[i].rxd, vecs[i].rden,
                      vecs[i].wren, vecs[i].wd, vecs[i].txr);
            applyStimulus();
            checkVal($sformatf("vec%0d.rx_count", i), rx_count_out, vecs[i].rxc);
            checkVal($sformatf("vec%0d.tx_count", i), tx_count_out, vecs[i].txc);
            checkVal($sformatf("vec%0d.rvalid", i), cpu_rvalid_out, vecs[i].rxc != 0);
            checkVal($sformatf("vec%0d.tx_valid", i), host_tx_valid_out, vecs[i].txc != 0);
            checkVal($sformatf("vec%0d.rx_ready", i), host_rx_ready_out, vecs[i].rxc < DEPTH);
            checkVal($sformatf("vec%0d.wready", i), cpu_wready_out, vecs[i].txc < DEPTH);
            checkVal($sformatf("vec%0d.underflow", i), rx_underflow_out, vecs[i].und);
            checkVal($sformatf("vec%0d.drop", i), tx_drop_out, vecs[i].drp);
            if (vecs[i].rxc != 0) checkVal($sformatf("vec%0d.rdata", i), cpu_rdata_out, vecs[i].rx_head);
            if (vecs[i].txc != 0) checkVal($sformatf("vec%0d.tx_data", i), host_tx_data_out, vecs[i].tx_head);
        end

        // Basic RX
        doReset();
        setInputs(1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        setInputs(1'b1, 1'b1, 8'h42, 1'b0, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        checkVal("basic_rx.rvalid", cpu_rvalid_out, 1);
        checkVal("basic_rx.rdata0", cpu_rdata_out, 8'h41);
        setInputs(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        checkVal("basic_rx.rdata1", cpu_rdata_out, 8'h42);
        checkVal("basic_rx.count", rx_count_out, 1);

        // TX fill beyond capacity, then drain in order
        doReset();
        for (int i = 1; i <= 9; i++) begin
            setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b0);
            applyStimulus();
            if (i == 7) checkVal("tx_fill.wready_7", cpu_wready_out, 1);
            if (i == 8) checkVal("tx_fill.wready_8", cpu_wready_out, 0);
        end
        checkVal("tx_fill.count", tx_count_out, 8);
        checkVal("tx_fill.drop", tx_drop_out, 1);
        for (int i = 1; i <= 8; i++) begin
            checkVal($sformatf("tx_drain.valid%0d", i), host_tx_valid_out, 1);
            checkVal($sformatf("tx_drain.data%0d", i), host_tx_data_out, i);
            setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1);
            applyStimulus();
        end
        checkVal("tx_drain.empty", host_tx_valid_out, 0);
        checkVal("tx_drain.count", tx_count_out, 0);

        // 20 bytes streamed through RX with low occupancy, across pointer wrap
        doReset();
        for (int k = 0; k < 2; k++) begin
            setInputs(1'b1, 1'b1, 8'(8'hA0 + k), 1'b0, 1'b0, 8'h00, 1'b0);
            applyStimulus();
        end
        for (int k = 2; k < 20; k++) begin
            checkVal($sformatf("wrap.byte%0d", k - 2), cpu_rdata_out, 8'hA0 + k - 2);
            setInputs(1'b1, 1'b1, 8'(8'hA0 + k), 1'b1, 1'b0, 8'h00, 1'b0);
            applyStimulus();
            checkVal($sformatf("wrap.count%0d", k), rx_count_out, 2);
        end
        for (int k = 18; k < 20; k++) begin
            checkVal($sformatf("wrap.byte%0d", k), cpu_rdata_out, 8'hA0 + k);
            setInputs(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
            applyStimulus();
        end
        checkVal("wrap.final_count", rx_count_out, 0);

        // Full RX with simultaneous push and pop: push refused
        doReset();
        for (int i = 0; i < 8; i++) begin
            setInputs(1'b1, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 8'h00, 1'b0);
            applyStimulus();
        end
        checkVal("full_pop.ready_full", host_rx_ready_out, 0);
        setInputs(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        checkVal("full_pop.count", rx_count_out, 7);
        checkVal("full_pop.ready", host_rx_ready_out, 1);
        checkVal("full_pop.head", cpu_rdata_out, 8'h11);
        checkOutput("full_pop");

        // Empty TX with simultaneous push and pop: pop ignored
        doReset();
        setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b1);
        applyStimulus();
        checkVal("empty_push.count", tx_count_out, 1);
        checkVal("empty_push.valid", host_tx_valid_out, 1);
        checkVal("empty_push.data", host_tx_data_out, 8'h5A);

        // Reset mid-operation with both FIFOs half full and both flags set
        doReset();
        setInputs(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus();
        for (int i = 0; i < 9; i++) begin
            setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'(i), 1'b0);
            applyStimulus();
        end
        for (int i = 0; i < 4; i++) begin
            setInputs(1'b1, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 8'h00, 1'b1);
            applyStimulus();
        end
        checkOutput("pre_reset");
        setInputs(1'b0, 1'b1, 8'h99, 1'b1, 1'b1, 8'h99, 1'b1);
        applyStimulus();
        setInputs(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        checkVal("mid_reset.rx_count",  rx_count_out,      0);
        checkVal("mid_reset.tx_count",  tx_count_out,      0);
        checkVal("mid_reset.underflow", rx_underflow_out,  0);
        checkVal("mid_reset.drop",      tx_drop_out,       0);
        checkVal("mid_reset.rvalid",    cpu_rvalid_out,    0);
        checkVal("mid_reset.tx_valid",  host_tx_valid_out, 0);
        checkVal("mid_reset.rx_ready",  host_rx_ready_out, 1);
        checkVal("mid_reset.wready",    cpu_wready_out,    1);

        // Randomized traffic: fill-biased first half, drain-biased second half
        doReset();
        for (int n = 0; n < 600; n++) begin
            int push_pct;
            push_pct = (n < 300) ? 65 : 35;
            setInputs($urandom_range(0, 59) != 0,
                      $urandom_range(0, 99) < push_pct, 8'($urandom),
                      $urandom_range(0, 99) >= push_pct,
                      $urandom_range(0, 99) < push_pct, 8'($urandom),
                      $urandom_range(0, 99) >= push_pct);
            applyStimulus();
            checkOutput("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/serial_fifo_bridge.md
SERIAL_FIFO_BRIDGE -- requirements
Module: serial_fifo_bridge

Interface
REQ-001 The module SHALL have a parameter DEPTH, default 8, giving the entry count of each FIFO; it must be a power of two and at least 2.
REQ-002 The module SHALL have a port clock, input, 1 bit, the sole clock; all state updates occur on its rising edge.
REQ-003 The module SHALL have a port reset, input, 1 bit: reset, synchronous, active-low.
REQ-004 The module SHALL have a port cpu_rdata_out, output, 8 bits: the RX FIFO head byte, which drives the processor's serial_in.
REQ-005 The module SHALL have a port cpu_rvalid_out, output, 1 bit: RX FIFO non-empty, which drives the processor's serial_valid_in.
REQ-006 The module SHALL have a port cpu_rden_in, input, 1 bit: RX pop request, driven by the processor's serial_rden_out.
REQ-007 The module SHALL have a port cpu_wdata_in, input, 8 bits: TX byte, driven by the processor's serial_out.
REQ-008 The module SHALL have a port cpu_wren_in, input, 1 bit: TX push request, driven by the processor's serial_wren_out.
REQ-009 The module SHALL have a port cpu_wready_out, output, 1 bit: TX FIFO not full, which drives the processor's serial_ready_in.
REQ-010 The module SHALL have host-side RX ports host_rx_data_in (input, 8 bits), host_rx_valid_in (input, 1 bit) and host_rx_ready_out (output, 1 bit), forming a valid/ready byte stream into the RX FIFO.
REQ-011 The module SHALL have host-side TX ports host_tx_data_out (output, 8 bits), host_tx_valid_out (output, 1 bit) and host_tx_ready_in (input, 1 bit), forming a valid/ready byte stream out of the TX FIFO.
REQ-012 The module SHALL have ports rx_count_out and tx_count_out, outputs, log2(DEPTH)+1 bits each, giving the current occupancy of each FIFO.
REQ-013 The module SHALL have ports rx_underflow_out and tx_drop_out, outputs, 1 bit each, as sticky error flags.

Function
REQ-014 Both FIFOs SHALL be first-word-fall-through, so that the head byte is on cpu_rdata_out and host_tx_data_out in the same cycle the corresponding valid output is high.
REQ-015 The bridge SHALL drive host_rx_ready_out with the expression rx_count_out < DEPTH; an RX push occurs on an edge where host_rx_valid_in and host_rx_ready_out are both 1.
REQ-016 An RX pop SHALL occur on an edge where cpu_rden_in and cpu_rvalid_out are both 1; the new head appears the next cycle.
REQ-017 A TX push SHALL occur on an edge where cpu_wren_in and cpu_wready_out are both 1; a TX pop occurs on an edge where host_tx_valid_out and host_tx_ready_in are both 1.
REQ-018 Simultaneous push and pop on one FIFO SHALL leave the count unchanged, with the push data going to the tail and the head advancing.
REQ-019 A full FIFO SHALL never be bypassed: ready is computed from the pre-edge count, so a push on a full FIFO is not accepted even when a pop occurs on the same edge.
REQ-020 A pop on an empty FIFO SHALL never pass the same-edge push through: the pop is ignored, the push is accepted, and the count becomes 1.
REQ-021 When cpu_rden_in=1 on an edge where the RX FIFO is empty, rx_underflow_out SHALL be set to 1 and held until reset, and the RX FIFO state stays unchanged.
REQ-022 When cpu_wren_in=1 on an edge where the TX FIFO is full, the byte SHALL be discarded and tx_drop_out set to 1 and held until reset.
REQ-023 Read and write pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; the count is tracked separately and never exceeds DEPTH or goes below 0.
REQ-024 The two FIFOs SHALL be fully independent, so that events on one never stall or alter the other.
REQ-025 host_tx_data_out and cpu_rdata_out SHALL show stale but stable data while the corresponding valid output is 0; their content is then don't-care.

Reset
REQ-026 On a rising edge with reset=0, all pointers, both counts and both sticky flags SHALL be cleared to 0.
REQ-027 During and after reset, cpu_rvalid_out and host_tx_valid_out SHALL be 0, and cpu_wready_out and host_rx_ready_out SHALL be 1.
REQ-028 Reset mid-transfer SHALL take priority over any push or pop on the same edge, and FIFO contents are lost.
REQ-029 Storage arrays need not be cleared on reset.

Verification
REQ-030 The bench SHALL cover basic RX: host pushes 0x41, 0x42 -> cpu_rvalid_out=1 with rdata=0x41; after one cpu_rden_in, rdata=0x42 and rx_count_out=1.
REQ-031 The bench SHALL cover TX fill: 9 back-to-back cpu_wren_in with host_tx_ready_in=0 and DEPTH=8 -> first 8 stored, cpu_wready_out=0 after the 8th, the 9th dropped, tx_drop_out=1; draining outputs bytes 1..8 in order.
REQ-032 The bench SHALL cover wrap-around: 20 bytes streamed through the RX FIFO while occupancy stays between 1 and 3 -> all 20 bytes are received in order and counts stay correct across pointer wrap.
REQ-033 The bench SHALL cover full with simultaneous pop: RX holds 8 bytes, host_rx_valid_in=1 and cpu_rden_in=1 on the same edge -> push refused, count becomes 7, host_rx_ready_out=1 the next cycle.
REQ-034 The bench SHALL cover empty with simultaneous push: TX empty, cpu_wren_in=1 (0x5A) and host_tx_ready_in=1 -> count 1, no pop; the next cycle host_tx_data_out=0x5A and host_tx_valid_out=1.
REQ-035 The bench SHALL cover reset mid-operation: both FIFOs half full, reset=0 for one edge -> counts 0, flags 0, valid outputs 0, ready outputs 1.
